fetch_prefetch_queue: RTL and testbench
=======================================

Name: fetch_prefetch_queue

Overview:
- Instruction fetch front-end that replaces the single-cycle PC/instruction-memory path upstream of the IF/ID register.
- Issues sequential fetch requests to a variable-latency instruction memory over a req/gnt + rvalid handshake.
- Buffers returned instructions with their PCs in an in-order queue and presents one instruction per cycle to IF/ID.
- Absorbs hazard stalls and branch redirects, discarding wrong-path responses that are still in flight.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after start
NOP_INSTR, 32'h0000_0013, instruction driven when the queue is empty (addi x0,x0,0)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
start_i  in  1  level; fetching begins on the first rising edge with start_i=1
stall_i  in  1  hazard stall from the decode side; holds the queue head
redirect_i  in  1  taken branch resolved in ID; one-cycle pulse
redirect_pc_i  in  32  branch target
imem_req_o  out  1  fetch request valid
imem_addr_o  out  32  fetch address, word aligned
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid, returned in request order
imem_rdata_i  in  32  response instruction
instr_valid_o  out  1  queue head valid
instr_o  out  32  queue head instruction, or NOP_INSTR when empty
pc_o  out  32  PC of the queue head, 0 when empty

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE; fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0.
  - Outputs: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=NOP_INSTR, pc_o=0.
- FSM has two states, IDLE and RUN.
  - IDLE->RUN on the first edge with start_i=1.
  - RUN never returns to IDLE except by reset. Reset mid-operation discards all state, including in-flight responses.
- Issue:
  - imem_req_o=1 iff state=RUN, !redirect_i, and (count+outstanding) < DEPTH. This reservation guarantees every response has a slot.
  - imem_addr_o=fetch_pc. imem_addr_o and imem_req_o stay stable until gnt.
  - On req&gnt: fetch_pc+=4 (mod 2^32 wrap), outstanding+=1.
- Response:
  - On imem_rvalid_i: outstanding-=1.
  - If drop_cnt>0, the response is discarded and drop_cnt-=1.
  - Otherwise {imem_rdata_i, resp_pc} is enqueued, and resp_pc+=4. resp_pc tracks the address of the oldest outstanding request.
  - Minimum latency is gnt edge -> rvalid next cycle -> visible at instr_o the cycle after (registered queue).
- Dequeue: the head pops on an edge with instr_valid_o=1 and stall_i=0.
- Simultaneous enqueue and dequeue are both performed; count is unchanged.
- Redirect (priority over everything):
  - Queue is cleared and fetch_pc=resp_pc=redirect_pc_i.
  - drop_cnt = outstanding + (gnt this cycle ? 1 : 0) − (rvalid this cycle ? 1 : 0). A response arriving in the redirect cycle is itself dropped.
  - Pending drop_cnt accumulates across back-to-back redirects.
- Redirect and stall in the same cycle: redirect wins; the head is discarded, not held.
- Redirect while in IDLE is ignored.
- redirect_pc_i[1:0] are ignored (forced to 0).
- Empty queue: instr_valid_o=0, instr_o=NOP_INSTR, pc_o=0. stall_i has no effect.
- Full queue with stall_i=1: no new requests issue (reservation rule); no overflow is possible.
- Assertions:
  - rvalid with outstanding=0 never occurs.
  - count never exceeds DEPTH.

Decomposition:
- Shared CPU package holds:
  - the NOP_INSTR constant,
  - PC width 32 and the instruction-width constant,
  - the fetch FSM state enum {IDLE, RUN}.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO.
  - 64-bit entries {pc, instr}.
  - Ports: push, pop, clear, full, empty, count, head data.
  - Same async active-low reset.
- The top block holds the FSM, PC counters, outstanding/drop counters and handshake logic.

Test Plan:
- Reset then start_i=1, memory gnt=1 and 1-cycle latency, stall_i=0 → imem_addr_o 0,4,8,...; instr_valid_o first high 2 cycles after the first gnt, pc_o=0 with the memory word at 0, then one instruction per cycle in order.
- stall_i=1 for 6 cycles → head held (pc_o constant); at most DEPTH=4 entries plus outstanding requests are reserved, imem_req_o drops to 0; after release, PCs continue without gaps or duplicates.
- 3-cycle memory latency with 2 requests outstanding, redirect_i to 32'h0000_0100 → both stale responses dropped; next instr_valid_o shows pc_o=32'h100; no 0x8/0xC instruction is ever emitted.
- Redirect in the same cycle as rvalid and gnt → drop_cnt correctly counts the new in-flight request; the rvalid word is discarded; the first valid PC is the target.
- Back-to-back redirects to 0x200 then 0x300 with a slow memory → only PC 0x300 and its successors appear.
- rst_i asserted mid-fetch with 2 requests outstanding → outputs return to reset values immediately (asynchronously); after restart, late responses from before reset are not required to be handled. The bench's memory model is also reset; the first pc_o is RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared CPU front-end definitions: datapath widths, the canonical NOP and
// the fetch FSM state encoding.
package fetch_prefetch_queue_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    // addi x0,x0,0
    localparam logic [INSTR_W-1:0] CPU_NOP = 32'h0000_0013;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// In-order {pc, instr} queue between the fetch handshake and IF/ID.
// The head is read straight out of the storage array, so an entry written on
// one edge is visible on the following cycle.
module fetch_fifo
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PC_W + INSTR_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (int'(count_q) == DEPTH);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Prefetching instruction fetch front-end: sequential req/gnt fetches, an
// in-order response queue, stall absorption and redirect with stale-drop.
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int                 DEPTH     = 4,
    parameter logic [PC_W-1:0]    RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = CPU_NOP
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_state_e state_q, state_d;

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  resp_pc_q, resp_pc_d;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    drop_cnt_q, drop_cnt_d;

    logic             running;
    logic             redirect_en;
    logic             req_fire;
    logic             push, pop;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [PC_W+INSTR_W-1:0] head;
    logic [PC_W-1:0]  redirect_tgt;

    assign running      = (state_q == RUN);
    assign redirect_en  = running && redirect_i;
    assign redirect_tgt = redirect_pc_i & ~(PC_W'(3));
    assign req_fire     = imem_req_o && imem_gnt_i;

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. Every request reserves a queue slot for its response,
    // so the queue can never overflow regardless of stalls.
    always_comb begin
        imem_req_o  = running && !redirect_i &&
                      ((int'(fifo_count) + int'(outstanding_q)) < DEPTH);
        imem_addr_o = fetch_pc_q;
    end

    // Counters. On redirect, everything still in flight after this edge is
    // stale, which is exactly the next outstanding count.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rvalid_i);
        drop_cnt_d    = drop_cnt_q;
        push          = 1'b0;
        if (redirect_en) begin
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (imem_rvalid_i) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - 1'b1;
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign pop = !fifo_empty && !stall_i && !redirect_en;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + INSTR_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (redirect_en),
        .wdata_i ({resp_pc_q, imem_rdata_i}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .rdata_o (head)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_empty ? NOP_INSTR : head[INSTR_W-1:0];
    assign pc_o          = fifo_empty ? '0 : head[PC_W+INSTR_W-1:INSTR_W];

    a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_i)
        imem_rvalid_i |-> (outstanding_q != '0));
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_i)
        int'(fifo_count) <= DEPTH);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
        push |-> !fifo_full);

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: startup/stall vector table, redirect and
// reset corner sequences, then randomized traffic against an epoch-tagged model.
module tb_fetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    int checks = 0;
    int errors = 0;

    fetch_prefetch_queue #(
        .DEPTH     (DEPTH),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: memory in-flight list tagged with the redirect epoch it
    // was issued in, plus the queue of PCs IF/ID should still see.
    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } fl_t;

    fl_t         infl[$];
    logic [31:0] mq[$];
    bit          run = 1'b0;
    logic [31:0] m_fetch = RESET_PC;
    int          epoch = 0;
    int          cyc = 0;
    int          lat = 1;
    int          gnt_pct = 100;

    // Memory side: responds in order once the head request's latency has elapsed.
    always @(posedge clk_i) begin
        cyc++;
        #1;
        imem_gnt_i = ($urandom_range(0, 99) < 32'(gnt_pct));
        if (infl.size() > 0 && infl[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(infl[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
    end

    always @(negedge clk_i) begin
        bit  exp_req;
        bit  rsp;
        fl_t r;
        if (!rst_i) begin
            infl.delete();
            mq.delete();
            run     = 1'b0;
            m_fetch = RESET_PC;
            epoch++;
        end else begin
            exp_req = run && !redirect_i && ((mq.size() + infl.size()) < DEPTH);
            chk("m_req", 32'(imem_req_o), 32'(exp_req));
            chk("m_addr", imem_addr_o, m_fetch);
            chk("m_valid", 32'(instr_valid_o), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("m_pc", pc_o, mq[0]);
                chk("m_instr", instr_o, mem_word(mq[0]));
            end else begin
                chk("m_pc_empty", pc_o, 32'h0);
                chk("m_instr_nop", instr_o, NOP);
            end
            rsp = imem_rvalid_i && (infl.size() > 0);
            if (rsp) r = infl.pop_front();
            if (run && redirect_i) begin
                mq.delete();
                epoch++;
                m_fetch = redirect_pc_i & 32'hFFFF_FFFC;
            end else begin
                if (mq.size() > 0 && !stall_i) void'(mq.pop_front());
                if (rsp && r.ep == epoch) mq.push_back(r.addr);
                if (exp_req && imem_gnt_i) begin
                    infl.push_back('{m_fetch, epoch, cyc + lat});
                    m_fetch = m_fetch + 32'd4;
                end
            end
            if (start_i) run = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(imem_req_o), 32'h0);
        chk({tag, "_addr"}, imem_addr_o, RESET_PC);
        chk({tag, "_valid"}, 32'(instr_valid_o), 32'h0);
        chk({tag, "_instr"}, instr_o, NOP);
        chk({tag, "_pc"}, pc_o, 32'h0);
    endtask

    task automatic do_reset();
        tick();
        rst_i = 1'b0;
        start_i = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        repeat (2) tick();
        rst_i = 1'b1;
    endtask

    task automatic wait_inflight(input int n, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (infl.size() >= n) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for %0d outstanding, got %0d", name, n, infl.size());
        end
    endtask

    task automatic expect_first_pc(input string name, input logic [31:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk_i);
            if (instr_valid_o) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: timeout, no valid instruction, required pc %h", name, exp);
        end else if (pc_o !== exp) begin
            errors++;
            $display("FAIL %s: first pc_o %h required %h", name, pc_o, exp);
        end
    endtask

    typedef struct {
        bit          start;
        bit          stall;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;

        // start, stall, req, addr, valid, pc ; gnt=1, latency 1
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h08};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h08};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h08};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h08};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h08};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h14};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 32'h24, 1'b1, 32'h18};

        #1;
        chk_reset_outputs("por");

        lat = 1;
        gnt_pct = 100;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            tick();
            start_i = tbl[i].start;
            stall_i = tbl[i].stall;
            @(negedge clk_i);
            chk($sformatf("tbl%0d_req", i), 32'(imem_req_o), 32'(tbl[i].req));
            chk($sformatf("tbl%0d_addr", i), imem_addr_o, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), 32'(instr_valid_o), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_pc", i), pc_o, tbl[i].pc);
            if (tbl[i].valid) chk($sformatf("tbl%0d_instr", i), instr_o, mem_word(tbl[i].pc));
        end
        tick();
        stall_i = 1'b0;
        repeat (5) tick();

        // Slow memory with two requests in flight, then redirect.
        lat = 3;
        do_reset();
        start_i = 1'b1;
        wait_inflight(2, "redir_slow", ok);
        if (ok) begin
            redirect_i = 1'b1;
            redirect_pc_i = 32'h0000_0100;
            tick();
            redirect_i = 1'b0;
            expect_first_pc("redir_slow_first", 32'h0000_0100);
        end
        repeat (10) tick();

        // Redirect in a cycle that also carries rvalid and gnt.
        lat = 1;
        do_reset();
        start_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (i > 4 && imem_rvalid_i && imem_gnt_i && imem_req_o) ok = 1'b1;
        end
        chk("redir_rv_window", 32'(ok), 32'h1);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0180;
        tick();
        redirect_i = 1'b0;
        expect_first_pc("redir_rv_first", 32'h0000_0180);
        repeat (10) tick();

        // Back-to-back redirects, second target misaligned.
        lat = 4;
        do_reset();
        start_i = 1'b1;
        wait_inflight(2, "b2b", ok);
        if (ok) begin
            redirect_i = 1'b1;
            redirect_pc_i = 32'h0000_0200;
            tick();
            redirect_pc_i = 32'h0000_0302;
            tick();
            redirect_i = 1'b0;
            expect_first_pc("b2b_first", 32'h0000_0300);
        end
        repeat (15) tick();

        // Asynchronous reset mid-fetch, redirect while idle, restart.
        lat = 3;
        do_reset();
        start_i = 1'b1;
        wait_inflight(2, "midreset", ok);
        #1;
        rst_i = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        start_i = 1'b0;
        lat = 1;
        repeat (2) tick();
        rst_i = 1'b1;
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0400;
        tick();
        redirect_i = 1'b0;
        start_i = 1'b1;
        expect_first_pc("restart_first", RESET_PC);
        repeat (10) tick();

        // Randomized traffic checked by the model every cycle.
        do_reset();
        start_i = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (i % 200 == 0) begin
                lat = int'($urandom_range(1, 4));
                gnt_pct = (i % 600 == 0) ? 100 : int'($urandom_range(30, 90));
            end
            stall_i = ($urandom_range(0, 99) < 30);
            redirect_i = ($urandom_range(0, 99) < 4);
            redirect_pc_i = $urandom & 32'h0000_FFFF;
        end
        tick();
        stall_i = 1'b0;
        redirect_i = 1'b0;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
